serial_nibble_adder_ctrl: RTL and testbench

//  Sequencer that adds two multi-nibble operands using one shared 4-bit adder slice.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/nibble_add_slice.sv | 19 +
 rtl/serial_nibble_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_nibble_adder_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial nibble adder.
//   - NIBBLE_W : width of the shared adder slice
//   - state_e  : sequencer states (IDLE, ADD, DONE)
//   - idx_width: width of the nibble index counter for a given operand size
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // $clog2(2) is 1, but guard anyway so a counter never collapses to zero bits.
  function automatic int idx_width(input int nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational 4-bit adder slice: {co, s} = a + b + ci.
// Ports:
//   a, b : NIBBLE_W-bit addends
//   ci   : carry in
//   s    : NIBBLE_W-bit sum
//   co   : carry out
module nibble_add_slice
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// Serial multi-nibble adder: adds two W-bit operands (W = 4*NIBBLES) one
// nibble per clock, LSB first, through a single shared 4-bit adder slice.
// The inter-nibble carry lives in a register.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active high
//   start : request, accepted whenever busy is low (IDLE or DONE)
//   A, B  : operands, captured on an accepted start
//   Cin   : carry into nibble 0, captured on an accepted start
//   busy  : high while nibbles are being added
//   done  : one-cycle pulse, S/Cout hold the new result
//   S     : sum, held until the next operation completes
//   Cout  : carry out of the top nibble, held like S
module serial_nibble_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLES*NIBBLE_W-1:0]   A,
  input  logic [NIBBLES*NIBBLE_W-1:0]   B,
  input  logic                          Cin,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLES*NIBBLE_W-1:0]   S,
  output logic                          Cout
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;   // partial sum, fills from the top
  logic               carry_q, carry_d;
  logic [W-1:0]       s_q,     s_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  // The one and only adder: always fed from the low nibble of the shift regs.
  nibble_add_slice u_slice (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts start exactly like IDLE, giving back-to-back operation.
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = slice_co;
        sum_d   = {slice_s, sum_q[W-1:NIBBLE_W]};
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // sum_d already holds the final nibble in its top position.
          s_d     = sum_d;
          cout_d  = slice_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Self-checking bench for serial_nibble_adder_ctrl, one instance with
// NIBBLES=4 and one with NIBBLES=2. Expected sums come from plain integer
// addition of the operands the bench itself applied.
module tb_serial_nibble_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, cin4, busy4, done4, cout4;
  logic [15:0] a4, b4, s4;

  logic        start2, cin2, busy2, done2, cout2;
  logic [7:0]  a2, b2, s2;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int last_done [2] = '{-1, -1};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  serial_nibble_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );

  serial_nibble_adder_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int nib, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic st);
    if (nib == 4) begin a4 = a;      b4 = b;      cin4 = c; start4 = st; end
    else          begin a2 = a[7:0]; b2 = b[7:0]; cin2 = c; start2 = st; end
  endtask

  function automatic logic get_done(input int nib);
    return (nib == 4) ? done4 : done2;
  endfunction

  function automatic logic get_busy(input int nib);
    return (nib == 4) ? busy4 : busy2;
  endfunction

  // One operation: pulse start, follow it to done, compare against A+B+Cin.
  // Returns in the done cycle so the caller may issue the next start at once.
  task automatic do_op(input int nib, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input bit corrupt, input string tag);
    logic [16:0] full;
    int n, bc, k;
    if (nib == 4) full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    else          full = {8'd0, {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, c}};
    set_in(nib, a, b, c, 1'b1);
    tick();
    set_in(nib, a, b, c, 1'b0);
    n = 0; bc = 0;
    while (!get_done(nib) && n < 40) begin
      if (get_busy(nib)) bc++;
      if (corrupt && n == 1) set_in(nib, 16'hAAAA, 16'h5555, ~c, 1'b0);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, nib);
    check({tag, "_busy_cycles"}, bc, nib);
    check({tag, "_busy_at_done"}, get_busy(nib), 0);
    if (nib == 4) begin
      check({tag, "_S"}, s4, full[15:0]);
      check({tag, "_Cout"}, cout4, full[16]);
    end else begin
      check({tag, "_S"}, s2, full[7:0]);
      check({tag, "_Cout"}, cout2, full[8]);
    end
    k = (nib == 4) ? 0 : 1;
    if (last_done[k] >= 0)
      check({tag, "_spacing"}, (cycle - last_done[k]) >= nib + 1, 1'b1);
    last_done[k] = cycle;
  endtask

  initial begin
    int n, dc, next_exp;
    rst = 1'b1;
    set_in(4, 16'h0, 16'h0, 1'b0, 1'b0);
    set_in(2, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_S4", s4, 0);
    check("rst_Cout4", cout4, 0);
    check("rst_busy2", busy2, 0);
    check("rst_S2", s2, 0);
    tick();

    // Basic add, then done must drop after one cycle
    do_op(4, 16'h1234, 16'h4321, 1'b0, 1'b0, "t1");
    tick();
    check("t1_done_one_cycle", done4, 0);
    check("t1_S_held", s4, 16'h5555);

    // Full carry ripple
    do_op(4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "t2a");
    tick();
    do_op(4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "t2b");
    tick();

    // start held high: done every NIBBLES+1 cycles, no restart while busy
    set_in(4, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    tick();
    next_exp = 4;
    dc = 0;
    for (n = 1; n <= 15; n++) begin
      tick();
      if (done4) begin
        dc++;
        check("t3_pulse_pos", n, next_exp);
        check("t3_S", s4, 16'h0100);
        check("t3_Cout", cout4, 0);
        next_exp = n + 5;
      end
    end
    check("t3_pulse_count", dc, 3);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin tick(); n++; end
    check("t3_drain_done", done4, 1);
    tick();
    last_done[0] = -1;

    // Operand changes during ADD are ignored
    do_op(4, 16'h1234, 16'h4321, 1'b0, 1'b1, "t4");
    tick();

    // Reset in 3rd ADD cycle aborts the operation
    set_in(4, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    tick();
    start4 = 1'b0;
    tick();
    tick();
    check("t5_busy_before_rst", busy4, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy4, 0);
    check("t5_done", done4, 0);
    check("t5_S", s4, 0);
    check("t5_Cout", cout4, 0);
    dc = 0;
    repeat (10) begin
      if (done4) dc++;
      tick();
    end
    check("t5_no_done", dc, 0);
    last_done[0] = -1;
    do_op(4, 16'h0F0F, 16'h0101, 1'b1, 1'b0, "t5_after");
    tick();

    // Random operations, with and without an idle gap between them
    for (int i = 0; i < 1000; i++) begin
      do_op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd4");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    for (int i = 0; i < 1000; i++) begin
      do_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd2");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    check("end_busy4", busy4, 0);
    check("end_busy2", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
